// File: rtl/vec_alu_sequencer_pkg.sv
// vec_alu_sequencer_pkg
// Shared widths, ALU function codes and FSM state encoding for the vector ALU
// sequencer. No ports; imported by the interface, the top and the testbench.
package vec_alu_sequencer_pkg;

    localparam int unsigned BITS  = 8;  // element width, matches ALU data width
    localparam int unsigned ALUOP = 4;  // ALU function code width
    localparam int unsigned ADDR  = 5;  // vector RAM address width, also length width

    localparam logic [ALUOP-1:0] ALU_MOV    = 4'd1;
    localparam logic [ALUOP-1:0] ALU_ADD    = 4'd2;
    localparam logic [ALUOP-1:0] ALU_SUB    = 4'd3;
    localparam logic [ALUOP-1:0] ALU_AND    = 4'd4;
    localparam logic [ALUOP-1:0] ALU_OR     = 4'd5;
    localparam logic [ALUOP-1:0] ALU_XOR    = 4'd6;
    localparam logic [ALUOP-1:0] ALU_SHL    = 4'd7;
    localparam logic [ALUOP-1:0] ALU_SHR    = 4'd8;
    localparam logic [ALUOP-1:0] ALU_ROL    = 4'd9;
    localparam logic [ALUOP-1:0] ALU_ROR    = 4'd10;
    localparam logic [ALUOP-1:0] ALU_OP_MAX = ALU_ROR;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } seq_state_e;

    // Codes 0 and anything above ALU_OP_MAX are rejected at acceptance.
    function automatic logic op_is_legal(input logic [ALUOP-1:0] op);
        return (op != '0) && (op <= ALU_OP_MAX);
    endfunction

endpackage

// File: rtl/vec_alu_sequencer_if.sv
// vec_alu_sequencer_if
// Bundles the command handshake, vector RAM read/write ports and ALU operand
// path of the sequencer.
//   master : sequencer side (accepts commands, drives RAM strobes/addresses and
//            ALU operands, reports busy/done/error)
//   slave  : environment side (decoder, vector RAM and ALU)
interface vec_alu_sequencer_if;
    import vec_alu_sequencer_pkg::*;

    // Command channel
    logic             cmdValid;
    logic             cmdReady;
    logic [ALUOP-1:0] cmdOp;
    logic [ADDR-1:0]  cmdSrcA;
    logic [ADDR-1:0]  cmdSrcB;
    logic [ADDR-1:0]  cmdDst;
    logic [ADDR-1:0]  cmdLen;
    // Vector RAM read ports (1-cycle latency)
    logic             rdEn;
    logic [ADDR-1:0]  rdAddrA;
    logic [ADDR-1:0]  rdAddrB;
    logic [BITS-1:0]  rdDataA;
    logic [BITS-1:0]  rdDataB;
    // ALU
    logic [ALUOP-1:0] aluFunction;
    logic [BITS-1:0]  vectorA;
    logic [BITS-1:0]  vectorB;
    logic [BITS-1:0]  aluResult;
    // Vector RAM write port
    logic             wrEn;
    logic [ADDR-1:0]  wrAddr;
    logic [BITS-1:0]  wrData;
    // Status
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        input  cmdValid, cmdOp, cmdSrcA, cmdSrcB, cmdDst, cmdLen,
        input  rdDataA, rdDataB, aluResult,
        output cmdReady, rdEn, rdAddrA, rdAddrB, aluFunction, vectorA, vectorB,
        output wrEn, wrAddr, wrData, busy, done, error
    );

    modport slave (
        output cmdValid, cmdOp, cmdSrcA, cmdSrcB, cmdDst, cmdLen,
        output rdDataA, rdDataB, aluResult,
        input  cmdReady, rdEn, rdAddrA, rdAddrB, aluFunction, vectorA, vectorB,
        input  wrEn, wrAddr, wrData, busy, done, error
    );

endinterface

// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer
// Runs one vector command at a time through the 8-bit ALU at one element per
// cycle: read issue (RUN) -> execute/write-back one cycle later -> done pulse.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (aborts any command, no done pulse)
//   bus     : vec_alu_sequencer_if.master (command, RAM ports, ALU, status)
module vec_alu_sequencer
    import vec_alu_sequencer_pkg::*;
(
    input logic                  clk,
    input logic                  reset_n,
    vec_alu_sequencer_if.master  bus
);

    seq_state_e       state_q, state_d;
    logic [ALUOP-1:0] op_q, op_d;
    logic [ADDR-1:0]  src_a_q, src_a_d;
    logic [ADDR-1:0]  src_b_q, src_b_d;
    logic [ADDR-1:0]  dst_q, dst_d;
    logic [ADDR-1:0]  len_q, len_d;
    logic [ADDR-1:0]  idx_q, idx_d;
    logic             err_q, err_d;
    // Execute stage: element whose read was issued in the previous cycle
    logic             exe_valid_q, exe_valid_d;
    logic [ADDR-1:0]  exe_idx_q, exe_idx_d;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        src_a_d     = src_a_q;
        src_b_d     = src_b_q;
        dst_d       = dst_q;
        len_d       = len_q;
        idx_d       = idx_q;
        err_d       = err_q;
        exe_valid_d = (state_q == StRun);
        exe_idx_d   = idx_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cmdValid) begin
                    op_d    = bus.cmdOp;
                    src_a_d = bus.cmdSrcA;
                    src_b_d = bus.cmdSrcB;
                    dst_d   = bus.cmdDst;
                    len_d   = bus.cmdLen;
                    idx_d   = '0;
                    err_d   = !op_is_legal(bus.cmdOp);
                    // Empty or illegal commands skip straight to completion
                    if ((bus.cmdLen == '0) || !op_is_legal(bus.cmdOp)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                idx_d = idx_q + ADDR'(1);
                if (idx_q == len_q - ADDR'(1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            op_q        <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            exe_valid_q <= 1'b0;
            exe_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            exe_valid_q <= exe_valid_d;
            exe_idx_q   <= exe_idx_d;
        end
    end

    // Outputs decode only registered state; address sums wrap modulo 2^ADDR.
    always_comb begin
        bus.cmdReady    = (state_q == StIdle);
        bus.rdEn        = (state_q == StRun);
        bus.rdAddrA     = (state_q == StRun) ? src_a_q + idx_q : '0;
        bus.rdAddrB     = (state_q == StRun) ? src_b_q + idx_q : '0;
        bus.busy        = (state_q == StRun) || (state_q == StDrain);
        bus.done        = (state_q == StDone);
        bus.error       = (state_q == StDone) && err_q;
        bus.aluFunction = bus.busy ? op_q : '0;
        bus.wrEn        = exe_valid_q;
        bus.wrAddr      = exe_valid_q ? dst_q + exe_idx_q : '0;
        bus.vectorA     = exe_valid_q ? bus.rdDataA : '0;
        bus.vectorB     = exe_valid_q ? bus.rdDataB : '0;
        bus.wrData      = exe_valid_q ? bus.aluResult : '0;
    end

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// tb_vec_alu_sequencer
// Drives vec_alu_sequencer with directed and random vector commands against a
// 32-entry RAM (read-old on collision) and an ALU stand-in. Expected per-cycle
// strobes, addresses, data and final RAM image come from a step model that
// applies the element timing: element k read at cycle k+1, written at k+2.
module tb_vec_alu_sequencer;
    import vec_alu_sequencer_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    vec_alu_sequencer_if bus ();

    vec_alu_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] ram      [32];
    logic [7:0] load_img [32];
    logic [7:0] mram     [32];
    logic       load_all = 1'b0;

    function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [15:0] d;
        case (op)
            ALU_MOV: return a;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SHL: return a << b[2:0];
            ALU_SHR: return a >> b[2:0];
            ALU_ROL: begin d = {a, a} << b[2:0]; return d[15:8]; end
            ALU_ROR: begin d = {a, a} >> b[2:0]; return d[7:0]; end
            default: return 8'h00;
        endcase
    endfunction

    always_comb bus.aluResult = alu_ref(bus.aluFunction, bus.vectorA, bus.vectorB);

    always @(posedge clk) begin
        if (load_all) ram <= load_img;
        else if (bus.wrEn) ram[bus.wrAddr] <= bus.wrData;
        if (bus.rdEn) begin
            bus.rdDataA <= ram[bus.rdAddrA];
            bus.rdDataB <= ram[bus.rdAddrB];
        end
    end

    task automatic randomize_img();
        for (int i = 0; i < 32; i++) load_img[i] = 8'($urandom);
    endtask

    // Push load_img into the RAM and the model; returns at a falling edge.
    task automatic commit_img();
        load_all = 1'b1;
        @(posedge clk);
        #1 load_all = 1'b0;
        for (int i = 0; i < 32; i++) mram[i] = load_img[i];
        @(negedge clk);
    endtask

    task automatic check_ram(input string name);
        int errs;
        errs = 0;
        for (int i = 0; i < 32; i++) if (ram[i] !== mram[i]) errs++;
        n_cmp++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL %s ram image: %0d entries differ, want 0", name, errs);
        end
    endtask

    // Enter at a falling edge with the DUT idle. Returns at the falling edge of
    // the idle cycle after done.
    task automatic run_cmd(input logic [3:0] op, input logic [4:0] sa, input logic [4:0] sb,
                           input logic [4:0] dst, input logic [4:0] len,
                           input bit keep_valid, output int rd_cnt, output int wr_cnt);
        bit          legal, active;
        bit          e_run, e_exe, e_busy, e_done;
        int          last;
        logic [7:0]  pa, pb, na, nb, va, vb, wd;
        logic [4:0]  ra, rb, wa;
        logic [3:0]  fn;
        logic [5:0]  e_ctrl, a_ctrl;
        logic [42:0] e_data, a_data;

        legal  = (op >= 4'd1) && (op <= 4'd10);
        active = legal && (len != 0);
        last   = active ? int'(len) + 2 : 1;
        rd_cnt = 0;
        wr_cnt = 0;
        pa = 8'h00; pb = 8'h00; na = 8'h00; nb = 8'h00;

        n_cmp++;
        if (bus.cmdReady !== 1'b1) begin
            n_fail++;
            $display("FAIL cmdReady before accept: got %b want 1", bus.cmdReady);
        end
        bus.cmdOp   = op;
        bus.cmdSrcA = sa;
        bus.cmdSrcB = sb;
        bus.cmdDst  = dst;
        bus.cmdLen  = len;
        bus.cmdValid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmdValid = keep_valid;
        // Fields after acceptance must be ignored
        bus.cmdOp   = 4'($urandom);
        bus.cmdSrcA = 5'($urandom);
        bus.cmdSrcB = 5'($urandom);
        bus.cmdDst  = 5'($urandom);
        bus.cmdLen  = 5'($urandom);

        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            e_run  = active && (c <= int'(len));
            e_exe  = active && (c >= 2) && (c <= int'(len) + 1);
            e_busy = active && (c <= int'(len) + 1);
            e_done = (c == last);
            ra = e_run ? sa + 5'(c - 1) : 5'd0;
            rb = e_run ? sb + 5'(c - 1) : 5'd0;
            wa = e_exe ? dst + 5'(c - 2) : 5'd0;
            fn = e_busy ? op : 4'd0;
            va = e_exe ? pa : 8'h00;
            vb = e_exe ? pb : 8'h00;
            wd = e_exe ? alu_ref(op, pa, pb) : 8'h00;
            e_ctrl = {1'b0, e_run, e_exe, e_busy, e_done, e_done && !legal};
            a_ctrl = {bus.cmdReady, bus.rdEn, bus.wrEn, bus.busy, bus.done, bus.error};
            e_data = {ra, rb, wa, fn, va, vb, wd};
            a_data = {bus.rdAddrA, bus.rdAddrB, bus.wrAddr, bus.aluFunction,
                      bus.vectorA, bus.vectorB, bus.wrData};
            n_cmp++;
            if (a_ctrl !== e_ctrl) begin
                n_fail++;
                $display("FAIL ctrl op=%0d len=%0d cycle %0d: got rdy/rd/wr/busy/done/err=%b want %b",
                         op, len, c, a_ctrl, e_ctrl);
            end
            n_cmp++;
            if (a_data !== e_data) begin
                n_fail++;
                $display("FAIL data op=%0d len=%0d cycle %0d: got rA/rB/wA/fn/vA/vB/wD=%h want %h",
                         op, len, c, a_data, e_data);
            end
            if (bus.rdEn === 1'b1) rd_cnt++;
            if (bus.wrEn === 1'b1) wr_cnt++;
            // Reads in a cycle see only writes from earlier cycles
            if (e_run) begin na = mram[ra]; nb = mram[rb]; end
            if (e_exe) mram[wa] = wd;
            pa = na;
            pb = nb;
        end

        @(negedge clk);
        n_cmp++;
        if ({bus.cmdReady, bus.done, bus.busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL idle after done: got rdy/done/busy=%b want 100",
                     {bus.cmdReady, bus.done, bus.busy});
        end
        check_ram("run_cmd");
    endtask

    task automatic test_reset();
        bus.cmdValid = 1'b0;
        bus.cmdOp = '0; bus.cmdSrcA = '0; bus.cmdSrcB = '0; bus.cmdDst = '0; bus.cmdLen = '0;
        reset_n = 1'b0;
        #12;
        n_cmp++;
        if ({bus.cmdReady, bus.rdEn, bus.wrEn, bus.busy, bus.done, bus.error} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset ctrl: got %b want 100000",
                     {bus.cmdReady, bus.rdEn, bus.wrEn, bus.busy, bus.done, bus.error});
        end
        n_cmp++;
        if ({bus.rdAddrA, bus.rdAddrB, bus.wrAddr, bus.aluFunction, bus.vectorA, bus.vectorB,
             bus.wrData} !== 43'h0) begin
            n_fail++;
            $display("FAIL reset data: got %h want 0", {bus.rdAddrA, bus.rdAddrB, bus.wrAddr,
                     bus.aluFunction, bus.vectorA, bus.vectorB, bus.wrData});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int rc, wc;
        logic [7:0] exp_res [4];
        exp_res = '{8'd11, 8'd22, 8'd33, 8'd44};
        randomize_img();
        load_img[0] = 8'd1;  load_img[1] = 8'd2;  load_img[2] = 8'd3;  load_img[3] = 8'd4;
        load_img[8] = 8'd10; load_img[9] = 8'd20; load_img[10] = 8'd30; load_img[11] = 8'd40;
        commit_img();
        run_cmd(ALU_ADD, 5'd0, 5'd8, 5'd16, 5'd4, 1'b0, rc, wc);
        n_cmp++;
        if (wc != 4) begin
            n_fail++;
            $display("FAIL add wrEn pulses: got %0d want 4", wc);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ram[16+i] !== exp_res[i]) begin
                n_fail++;
                $display("FAIL add ram[%0d]: got %0d want %0d", 16 + i, ram[16+i], exp_res[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int rc, wc;
        logic [7:0] want [3];
        randomize_img();
        commit_img();
        want[0] = load_img[30] - load_img[0];
        want[1] = load_img[31] - load_img[1];
        want[2] = load_img[0]  - load_img[2];
        run_cmd(ALU_SUB, 5'd30, 5'd0, 5'd31, 5'd3, 1'b0, rc, wc);
        n_cmp++;
        if ({ram[31], ram[0], ram[1]} !== {want[0], want[1], want[2]}) begin
            n_fail++;
            $display("FAIL wrap results: got %h want %h", {ram[31], ram[0], ram[1]},
                     {want[0], want[1], want[2]});
        end
    endtask

    task automatic test_empty_illegal();
        int rc, wc;
        logic [3:0] ops  [5];
        logic [4:0] lens [5];
        ops  = '{4'd2, 4'd0, 4'd12, 4'd15, 4'd11};
        lens = '{5'd0, 5'd4, 5'd3,  5'd0,  5'd1};
        for (int i = 0; i < 5; i++) begin
            run_cmd(ops[i], 5'($urandom), 5'($urandom), 5'($urandom), lens[i], 1'b0, rc, wc);
            n_cmp++;
            if ((rc != 0) || (wc != 0)) begin
                n_fail++;
                $display("FAIL empty op=%0d len=%0d strobes: got rd=%0d wr=%0d want 0/0",
                         ops[i], lens[i], rc, wc);
            end
        end
    endtask

    task automatic test_back_to_back();
        int rc, wc;
        run_cmd(ALU_XOR, 5'd2, 5'd12, 5'd20, 5'd5, 1'b1, rc, wc);
        run_cmd(ALU_AND, 5'd20, 5'd3, 5'd8, 5'd3, 1'b1, rc, wc);
        run_cmd(ALU_MOV, 5'd8, 5'd9, 5'd25, 5'd2, 1'b0, rc, wc);
    endtask

    task automatic test_rotate();
        int rc, wc;
        randomize_img();
        load_img[0] = 8'h81;
        load_img[8] = 8'h01;
        commit_img();
        run_cmd(ALU_ROL, 5'd0, 5'd8, 5'd16, 5'd1, 1'b0, rc, wc);
        run_cmd(ALU_ROR, 5'd0, 5'd8, 5'd17, 5'd1, 1'b0, rc, wc);
        n_cmp++;
        if ({ram[16], ram[17]} !== 16'h03C0) begin
            n_fail++;
            $display("FAIL rotate: got %h want 03c0", {ram[16], ram[17]});
        end
        run_cmd(ALU_ROL, 5'd1, 5'd9, 5'd24, 5'd6, 1'b0, rc, wc);
        run_cmd(ALU_SHR, 5'd1, 5'd9, 5'd1, 5'd6, 1'b0, rc, wc);
    endtask

    task automatic test_random();
        int rc, wc;
        logic [3:0] op;
        randomize_img();
        commit_img();
        for (int i = 0; i < 20; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(1, 10));
            run_cmd(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom_range(0, 9)),
                    1'($urandom_range(0, 1)), rc, wc);
        end
        bus.cmdValid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int rc, wc;
        randomize_img();
        commit_img();
        bus.cmdOp = ALU_ADD; bus.cmdSrcA = 5'd0; bus.cmdSrcB = 5'd8;
        bus.cmdDst = 5'd16; bus.cmdLen = 5'd5;
        bus.cmdValid = 1'b1;
        @(posedge clk);
        #1 bus.cmdValid = 1'b0;
        // Cycle 3 issues element 2 and writes element 1; element 0 is already in RAM
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.cmdReady, bus.rdEn, bus.wrEn, bus.busy, bus.done, bus.error} !== 6'b100000) begin
            n_fail++;
            $display("FAIL async abort ctrl: got %b want 100000",
                     {bus.cmdReady, bus.rdEn, bus.wrEn, bus.busy, bus.done, bus.error});
        end
        mram[16] = mram[0] + mram[8];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.done, bus.wrEn, bus.rdEn} !== 3'b000) begin
                n_fail++;
                $display("FAIL abort hold %0d: got done/wr/rd=%b want 000", i,
                         {bus.done, bus.wrEn, bus.rdEn});
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
        check_ram("abort");
        run_cmd(ALU_ADD, 5'd0, 5'd8, 5'd16, 5'd5, 1'b0, rc, wc);
        n_cmp++;
        if (wc != 5) begin
            n_fail++;
            $display("FAIL after abort wrEn pulses: got %0d want 5", wc);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap();
        test_empty_illegal();
        test_back_to_back();
        test_rotate();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
